// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. A single one-bit full-adder slice is shared
// across a WIDTH-bit operand pair. The operands are latched on an accepted
// start request. The block then processes one bit per clock, LSB first, and
// holds the running carry in a flop between steps. When the last bit is
// processed, the sum and carry-out are registered and a one-cycle done pulse
// is raised.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, a 'sub' input is added. sub=1 computes a-b by loading ~b
//   and forcing the initial carry to 1; cin is then ignored, and cout=1 means
//   "no borrow". When undefined, the block is addition only.
//
// Parameters
//   WIDTH  operand/sum width in bits (2..32), default 8
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in, sampled on the accepting edge
//   sub    in   1      subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy   out  1      high while a computation is running
//   done   out  1      one-cycle pulse; sum/cout valid
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered final carry (no-borrow flag when subtracting)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Bit counter: just wide enough to index bits 0..WIDTH-1. RUN exits on
   // the last index, so the counter never has to wrap.
   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;    // operand A, shifted right each step
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;    // operand B (or ~B), shifted right
   logic             carry_q,  carry_d;   // carry between bit steps
   logic [CNT_W-1:0] cnt_q,    cnt_d;     // index of the bit being processed
   logic [WIDTH-1:0] acc_q,    acc_d;     // partial sum, filled from the MSB
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             cout_q,   cout_d;

   // Values loaded on an accepted request. For subtraction, a-b = a + ~b + 1,
   // so the B register takes the complement and the carry starts at 1.
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
   assign b_load     = sub ? ~b   : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   // The shared one-bit full-adder slice.
   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] acc_shift;

   assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign bit_c = (a_sh_q[0] & b_sh_q[0]) |
                  (a_sh_q[0] & carry_q)   |
                  (b_sh_q[0] & carry_q);

   // The new sum bit enters at the MSB. After WIDTH steps, bit 0 has moved
   // down to position 0 and the register holds the sum in natural order.
   assign acc_shift = {bit_s, acc_q[WIDTH-1:1]};

   // -------------------------------------------------------------------------
   // Next-state and datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a hold value before the case statement.
      // A path that leaves a signal unassigned would otherwise infer a latch.
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         RUN: begin
            // start is deliberately ignored here; requests are not queued.
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = bit_c;
            acc_d   = acc_shift;
            if (cnt_q == LAST_BIT) begin
               // The final bit completes on this edge. The result is
               // published here and nowhere else, so partial sums are never
               // visible on the outputs.
               sum_d   = acc_shift;
               cout_d  = bit_c;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and data registers
   // -------------------------------------------------------------------------
   // NOTE: the datapath registers are reset as well as the state. An
   // asynchronous reset in mid-computation must also clear sum/cout at once,
   // and a known-zero datapath keeps the block deterministic after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the
         // pre-edge values, whatever the statement order.
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: all taken directly from flops
   // -------------------------------------------------------------------------
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
